// File: rtl/itrx_aib_phy_rx_dist_bus_pkg.sv
// Shared limits, encodings and checker helper for the AIB RX distribution bus.
package itrx_aib_phy_rx_dist_bus_pkg;

  localparam int unsigned PIPE_MIN     = 1;
  localparam int unsigned PIPE_MAX     = 4;
  localparam int unsigned SYNC_STG_MIN = 2;
  localparam int unsigned SYNC_STG_MAX = 3;
  localparam int unsigned WARM_W       = 3;

  typedef enum logic {
    CHK_MODE_SDR = 1'b0,
    CHK_MODE_DDR = 1'b1
  } chk_mode_e;

  typedef enum logic {
    CHK_IDLE  = 1'b0,
    CHK_TRACK = 1'b1
  } chk_state_e;

  // A clock pattern must toggle every cycle; in DDR the odd half must be the complement.
  function automatic logic chk_pattern_bad(input logic d0, input logic prev0,
                                           input logic d1, input chk_mode_e mode);
    return (d0 == prev0) || ((mode == CHK_MODE_DDR) && (d1 != ~d0));
  endfunction

endpackage

// File: rtl/itrx_aib_phy_rx_dist_bus_if.sv
// RX distribution bus: bump inputs, configuration and retimed/checker outputs.
interface itrx_aib_phy_rx_dist_bus_if #(
  parameter int unsigned NCH       = 20,
  parameter int unsigned ERR_CNT_W = 16
);
  logic [NCH-1:0]       ubump_rx_0ql;
  logic [NCH-1:0]       ubump_rx_1q;
  logic [NCH-1:0]       ubump_rx_n;
  logic                 cfg_ddr_en;
  logic [NCH-1:0]       cfg_ch_en;
  logic                 rx_en;
  logic                 chk_en;
  logic                 chk_clr;
  logic [NCH-1:0]       odat0;
  logic [NCH-1:0]       odat1;
  logic                 odat_vld;
  logic [NCH-1:0]       odat_asyn;
  logic [NCH-1:0]       odat_asyn_sync;
  logic [NCH-1:0]       chk_err;
  logic [ERR_CNT_W-1:0] chk_err_cnt;

  modport master (
    output ubump_rx_0ql, ubump_rx_1q, ubump_rx_n, cfg_ddr_en, cfg_ch_en,
           rx_en, chk_en, chk_clr,
    input  odat0, odat1, odat_vld, odat_asyn, odat_asyn_sync, chk_err, chk_err_cnt
  );

  modport slave (
    input  ubump_rx_0ql, ubump_rx_1q, ubump_rx_n, cfg_ddr_en, cfg_ch_en,
           rx_en, chk_en, chk_clr,
    output odat0, odat1, odat_vld, odat_asyn, odat_asyn_sync, chk_err, chk_err_cnt
  );
endinterface

// File: rtl/itrx_aib_phy_rx_dist_chan.sv
// One RX channel: masked capture pipeline, async-data synchroniser, clock-pattern checker.
module itrx_aib_phy_rx_dist_chan
  import itrx_aib_phy_rx_dist_bus_pkg::*;
#(
  parameter int unsigned PIPE     = 1,
  parameter int unsigned SYNC_STG = 2
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_d0,
  input  logic i_d1,
  input  logic i_asyn,
  input  logic i_ch_en,
  input  logic i_ddr_en,
  input  logic i_vld,
  input  logic i_chk_en,
  input  logic i_chk_clr,
  output logic o_dat0,
  output logic o_dat1,
  output logic o_asyn_sync,
  output logic o_chk_err,
  output logic o_err_evt
);
  logic [PIPE:0]     w_p0;
  logic [PIPE:0]     w_p1;
  logic [SYNC_STG:0] w_sy;

  assign w_p0[0] = i_d0 & i_ch_en;
  assign w_p1[0] = i_d1 & i_ch_en & i_ddr_en;
  assign w_sy[0] = i_asyn;

  for (genvar s = 0; s < int'(PIPE); s++) begin : g_pipe
    itrx_aib_phy_stdcell_dff u_dff0 (.i_clk, .i_rst_n, .i_d(w_p0[s]), .o_q(w_p0[s+1]));
    itrx_aib_phy_stdcell_dff u_dff1 (.i_clk, .i_rst_n, .i_d(w_p1[s]), .o_q(w_p1[s+1]));
  end

  for (genvar s = 0; s < int'(SYNC_STG); s++) begin : g_sync
    itrx_aib_phy_stdcell_dff u_dff (.i_clk, .i_rst_n, .i_d(w_sy[s]), .o_q(w_sy[s+1]));
  end

  assign o_dat0      = w_p0[PIPE];
  assign o_dat1      = w_p1[PIPE];
  assign o_asyn_sync = w_sy[SYNC_STG];

  chk_state_e r_state;
  chk_state_e w_state_nxt;
  logic       r_prev0;
  logic       r_chk_err;
  logic       w_active;

  assign w_active = i_chk_en & i_vld & i_ch_en;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) r_state <= CHK_IDLE;
    else          r_state <= w_state_nxt;
  end

  // IDLE means the reference is not loaded: the next active cycle only samples it.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      CHK_IDLE:  if (w_active && !i_chk_clr) w_state_nxt = CHK_TRACK;
      CHK_TRACK: if (!w_active || i_chk_clr) w_state_nxt = CHK_IDLE;
      default:   w_state_nxt = CHK_IDLE;
    endcase
  end

  always_comb begin
    w_err_evt_default : begin
      o_err_evt = 1'b0;
      if (w_active && (r_state == CHK_TRACK))
        o_err_evt = chk_pattern_bad(o_dat0, r_prev0, o_dat1, chk_mode_e'(i_ddr_en));
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_prev0   <= 1'b0;
      r_chk_err <= 1'b0;
    end else begin
      if (w_active)       r_prev0   <= o_dat0;
      if (i_chk_clr)      r_chk_err <= 1'b0;
      else if (o_err_evt) r_chk_err <= 1'b1;
    end
  end

  assign o_chk_err = r_chk_err;
endmodule

// File: rtl/itrx_aib_phy_stdcell_dff.sv
// Single-bit D flop with asynchronous active-low clear.
module itrx_aib_phy_stdcell_dff (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_d,
  output logic o_q
);
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) o_q <= 1'b0;
    else          o_q <= i_d;
  end
endmodule

// File: rtl/itrx_aib_phy_rx_dist_bus.sv
// Multi-channel AIB RX distribution: per-channel retime/sync/check plus shared
// warm-up qualifier and saturating pattern-error counter.
module itrx_aib_phy_rx_dist_bus
  import itrx_aib_phy_rx_dist_bus_pkg::*;
#(
  parameter int unsigned NCH       = 20,
  parameter int unsigned PIPE      = 1,
  parameter int unsigned SYNC_STG  = 2,
  parameter int unsigned ERR_CNT_W = 16
) (
  input  logic                        inclk_dist,
  input  logic                        rx_irstb,
  itrx_aib_phy_rx_dist_bus_if.slave   bus
);
  if ((PIPE < PIPE_MIN) || (PIPE > PIPE_MAX)) begin : g_bad_pipe
    $error("itrx_aib_phy_rx_dist_bus: PIPE=%0d outside legal range", PIPE);
  end
  if ((SYNC_STG < SYNC_STG_MIN) || (SYNC_STG > SYNC_STG_MAX)) begin : g_bad_sync
    $error("itrx_aib_phy_rx_dist_bus: SYNC_STG=%0d outside legal range", SYNC_STG);
  end

  logic [WARM_W-1:0]    r_warm_cnt;
  logic                 r_rx_en_d;
  logic                 r_ddr_d;
  logic                 r_vld;
  logic [ERR_CNT_W-1:0] r_err_cnt;
  logic                 w_reload;
  logic [NCH-1:0]       w_asyn;
  logic [NCH-1:0]       w_odat0;
  logic [NCH-1:0]       w_odat1;
  logic [NCH-1:0]       w_sync;
  logic [NCH-1:0]       w_chk_err;
  logic [NCH-1:0]       w_err_evt;

  // Reload also suppresses odat_vld on that edge, so a stale zero count cannot leak through.
  assign w_reload = ~bus.rx_en | ~r_rx_en_d | (bus.cfg_ddr_en ^ r_ddr_d);

  always_ff @(posedge inclk_dist or negedge rx_irstb) begin
    if (!rx_irstb) begin
      r_warm_cnt <= '0;
      r_rx_en_d  <= 1'b0;
      r_ddr_d    <= 1'b0;
      r_vld      <= 1'b0;
    end else begin
      r_rx_en_d <= bus.rx_en;
      r_ddr_d   <= bus.cfg_ddr_en;
      if (w_reload)               r_warm_cnt <= WARM_W'(PIPE);
      else if (r_warm_cnt != '0)  r_warm_cnt <= r_warm_cnt - WARM_W'(1);
      r_vld <= bus.rx_en & ~w_reload & (r_warm_cnt == '0);
    end
  end

  always_ff @(posedge inclk_dist or negedge rx_irstb) begin
    if (!rx_irstb)                           r_err_cnt <= '0;
    else if (bus.chk_clr)                    r_err_cnt <= '0;
    else if ((|w_err_evt) && (r_err_cnt != '1)) r_err_cnt <= r_err_cnt + ERR_CNT_W'(1);
  end

  assign w_asyn = ~bus.ubump_rx_n;

  for (genvar i = 0; i < int'(NCH); i++) begin : g_ch
    itrx_aib_phy_rx_dist_chan #(
      .PIPE     (PIPE),
      .SYNC_STG (SYNC_STG)
    ) u_chan (
      .i_clk       (inclk_dist),
      .i_rst_n     (rx_irstb),
      .i_d0        (bus.ubump_rx_0ql[i]),
      .i_d1        (bus.ubump_rx_1q[i]),
      .i_asyn      (w_asyn[i]),
      .i_ch_en     (bus.cfg_ch_en[i]),
      .i_ddr_en    (bus.cfg_ddr_en),
      .i_vld       (r_vld),
      .i_chk_en    (bus.chk_en),
      .i_chk_clr   (bus.chk_clr),
      .o_dat0      (w_odat0[i]),
      .o_dat1      (w_odat1[i]),
      .o_asyn_sync (w_sync[i]),
      .o_chk_err   (w_chk_err[i]),
      .o_err_evt   (w_err_evt[i])
    );
  end

  assign bus.odat0          = w_odat0;
  assign bus.odat1          = w_odat1;
  assign bus.odat_vld       = r_vld;
  assign bus.odat_asyn      = w_asyn;
  assign bus.odat_asyn_sync = w_sync;
  assign bus.chk_err        = w_chk_err;
  assign bus.chk_err_cnt    = r_err_cnt;
endmodule

// File: tb/tb_itrx_aib_phy_rx_dist_bus.sv
// Directed bench for itrx_aib_phy_rx_dist_bus (NCH=20, PIPE=3, SYNC_STG=2, ERR_CNT_W=4).
module tb_itrx_aib_phy_rx_dist_bus;
  localparam int unsigned NCH       = 20;
  localparam int unsigned PIPE      = 3;
  localparam int unsigned SYNC_STG  = 2;
  localparam int unsigned ERR_CNT_W = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        ph;
  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;

  itrx_aib_phy_rx_dist_bus_if #(.NCH(NCH), .ERR_CNT_W(ERR_CNT_W)) bus ();

  itrx_aib_phy_rx_dist_bus #(
    .NCH       (NCH),
    .PIPE      (PIPE),
    .SYNC_STG  (SYNC_STG),
    .ERR_CNT_W (ERR_CNT_W)
  ) u_dut (
    .inclk_dist (clk),
    .rx_irstb   (rst_n),
    .bus        (bus)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Clock pattern: 0ql toggles every cycle, 1q is its complement; tie1q makes 1q equal
  // 0ql on the masked lanes, stuck holds 0ql=1/1q=0 on the masked lanes.
  task automatic drive_pat(input int unsigned n, input logic [NCH-1:0] tie1q,
                           input logic [NCH-1:0] stuck);
    logic [NCH-1:0] w;
    for (int unsigned k = 0; k < n; k++) begin
      ph = ~ph;
      w  = ph ? '1 : '0;
      bus.ubump_rx_0ql = w | stuck;
      bus.ubump_rx_1q  = (~w ^ tie1q) & ~stuck;
      tick();
    end
  endtask

  initial begin
    rst_n            = 1'b0;
    ph               = 1'b0;
    bus.ubump_rx_0ql = '0;
    bus.ubump_rx_1q  = '0;
    bus.ubump_rx_n   = '0;
    bus.cfg_ddr_en   = 1'b0;
    bus.cfg_ch_en    = '1;
    bus.rx_en        = 1'b0;
    bus.chk_en       = 1'b0;
    bus.chk_clr      = 1'b0;
    repeat (2) tick();

    chk("rst_odat0", 32'(bus.odat0), 32'h0);
    chk("rst_odat1", 32'(bus.odat1), 32'h0);
    chk("rst_vld", 32'(bus.odat_vld), 32'h0);
    chk("rst_sync", 32'(bus.odat_asyn_sync), 32'h0);
    chk("rst_err", 32'(bus.chk_err), 32'h0);
    chk("rst_cnt", 32'(bus.chk_err_cnt), 32'h0);
    chk("rst_asyn", 32'(bus.odat_asyn), 32'hFFFFF);

    rst_n = 1'b1;
    tick();

    // Warm-up: rx_en seen at edge N, odat_vld first high after edge N+PIPE+1
    bus.rx_en = 1'b1;
    repeat (4) tick();
    chk("warm_vld_lo", 32'(bus.odat_vld), 32'h0);
    tick();
    chk("warm_vld_hi", 32'(bus.odat_vld), 32'h1);

    // SDR latency with 1q toggling
    bus.ubump_rx_0ql = 20'h00001; bus.ubump_rx_1q = '1; tick();
    chk("lat_e1", 32'(bus.odat0), 32'h0);
    bus.ubump_rx_0ql = '0;        bus.ubump_rx_1q = '0; tick();
    chk("lat_e2", 32'(bus.odat0), 32'h0);
    bus.ubump_rx_1q = '1; tick();
    chk("lat_e3", 32'(bus.odat0), 32'h1);
    chk("lat_sdr_odat1", 32'(bus.odat1), 32'h0);
    bus.ubump_rx_1q = '0; tick();
    chk("lat_e4", 32'(bus.odat0), 32'h0);

    // Async path on lane 7
    bus.ubump_rx_n = 20'h00080;
    #1;
    chk("asyn_comb", 32'(bus.odat_asyn), 32'hFFF7F);
    tick();
    chk("asyn_sync_e1", 32'(bus.odat_asyn_sync), 32'hFFFFF);
    tick();
    chk("asyn_sync_e2", 32'(bus.odat_asyn_sync), 32'hFFF7F);

    // Switch to DDR with checker on
    bus.cfg_ddr_en = 1'b1;
    bus.chk_en     = 1'b1;
    drive_pat(4, '0, '0);
    chk("ddr_sw_vld_lo", 32'(bus.odat_vld), 32'h0);
    drive_pat(1, '0, '0);
    chk("ddr_sw_vld_hi", 32'(bus.odat_vld), 32'h1);
    drive_pat(100, '0, '0);
    chk("ddr_clean_err", 32'(bus.chk_err), 32'h0);
    chk("ddr_clean_cnt", 32'(bus.chk_err_cnt), 32'h0);
    chk("ddr_odat0", 32'(bus.odat0), ph ? 32'hFFFFF : 32'h0);
    chk("ddr_odat1", 32'(bus.odat1), ph ? 32'h0 : 32'hFFFFF);

    // Lane 5: 1q equal to 0ql for three cycles
    drive_pat(3, 20'h00020, '0);
    drive_pat(5, '0, '0);
    chk("force_err", 32'(bus.chk_err), 32'h20);
    chk("force_cnt", 32'(bus.chk_err_cnt), 32'h3);

    // Disable lanes 2 and 5
    bus.cfg_ch_en = ~20'h00024;
    drive_pat(3, '0, '0);
    chk("dis_odat0", 32'(bus.odat0), ph ? 32'hFFFDB : 32'h0);
    chk("dis_odat1", 32'(bus.odat1), ph ? 32'h0 : 32'hFFFDB);
    drive_pat(6, '0, '0);
    chk("dis_err_keep", 32'(bus.chk_err), 32'h20);
    chk("dis_cnt", 32'(bus.chk_err_cnt), 32'h3);

    // Clear, then saturate with lane 0 stuck
    bus.chk_clr = 1'b1; drive_pat(1, '0, '0); bus.chk_clr = 1'b0;
    chk("clr_err", 32'(bus.chk_err), 32'h0);
    chk("clr_cnt", 32'(bus.chk_err_cnt), 32'h0);
    drive_pat(24, '0, 20'h00001);
    chk("sat_cnt", 32'(bus.chk_err_cnt), 32'hF);
    chk("sat_err", 32'(bus.chk_err), 32'h1);

    // Clear wins over a simultaneous error, then one reference-load cycle
    bus.chk_clr = 1'b1; drive_pat(1, '0, 20'h00001); bus.chk_clr = 1'b0;
    chk("clr_hit_cnt", 32'(bus.chk_err_cnt), 32'h0);
    chk("clr_hit_err", 32'(bus.chk_err), 32'h0);
    drive_pat(1, '0, 20'h00001);
    chk("rearm_load", 32'(bus.chk_err_cnt), 32'h0);
    drive_pat(1, '0, 20'h00001);
    chk("rearm_cnt", 32'(bus.chk_err_cnt), 32'h1);
    chk("rearm_err", 32'(bus.chk_err), 32'h1);

    // rx_en fall: vld drops next edge; that edge still checks, later ones do not
    bus.rx_en = 1'b0;
    drive_pat(1, '0, 20'h00001);
    chk("rxen_fall_vld", 32'(bus.odat_vld), 32'h0);
    drive_pat(2, '0, 20'h00001);
    chk("rxen_fall_cnt", 32'(bus.chk_err_cnt), 32'h2);

    // Reset pulse mid-traffic
    bus.rx_en        = 1'b1;
    bus.ubump_rx_0ql = 20'($urandom);
    bus.ubump_rx_1q  = 20'($urandom);
    bus.ubump_rx_n   = 20'($urandom);
    tick();
    tick();
    #1;
    rst_n = 1'b0;
    #1;
    chk("rstmid_odat0", 32'(bus.odat0), 32'h0);
    chk("rstmid_odat1", 32'(bus.odat1), 32'h0);
    chk("rstmid_vld", 32'(bus.odat_vld), 32'h0);
    chk("rstmid_sync", 32'(bus.odat_asyn_sync), 32'h0);
    chk("rstmid_err", 32'(bus.chk_err), 32'h0);
    chk("rstmid_cnt", 32'(bus.chk_err_cnt), 32'h0);
    rst_n = 1'b1;
    repeat (4) tick();
    chk("rst_ret_vld_lo", 32'(bus.odat_vld), 32'h0);
    tick();
    chk("rst_ret_vld_hi", 32'(bus.odat_vld), 32'h1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
